// File: rtl/apb_regfile_pkg.sv
// rtl/apb_regfile_pkg.sv - shared FSM encoding, wait-counter width and address-error rule for apb_regfile
package apb_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // An index at or beyond the populated register count gets an error response.
  function automatic logic addr_err(input logic [31:0] idx, input int unsigned nregs);
    return (idx >= nregs);
  endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// rtl/apb_reg_cell.sv - one register with write enable, reset value and a one-cycle write pulse
module apb_reg_cell #(
  parameter int                DWIDTH    = 8,
  parameter logic [DWIDTH-1:0] RESET_VAL = '0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              we,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] q,
  output logic              wr_pulse
);

  // The pulse fires on every accepted write, even if the value is unchanged.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      q        <= RESET_VAL;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= we;
      if (we) begin
        q <= wdata;
      end
    end
  end

endmodule

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - APB register file with wait states and write pulses; APB_REGFILE_WAIT_EN enables WAIT_CYCLES
module apb_regfile
  import apb_regfile_pkg::*;
#(
  parameter int                DWIDTH      = 8,
  parameter int                NREGS       = 4,
  parameter int                AWIDTH      = 4,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DWIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [AWIDTH-1:0]       PADDR,
  input  logic [DWIDTH-1:0]       PWDATA,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [NREGS*DWIDTH-1:0] regs_out,
  output logic [NREGS-1:0]        wr_pulse
);

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [DWIDTH-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;

  logic                resp_go;
  logic                resp_err;
  logic [AWIDTH-1:0]   resp_addr;
  logic                resp_write;
  logic [DWIDTH-1:0]   rd_sel;
  logic                complete_wr;
  logic [DWIDTH-1:0]   reg_q [NREGS];
  logic [NREGS-1:0]    we;

`ifdef APB_REGFILE_WAIT_EN
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Out-of-range WAIT_CYCLES shows up as this scope in the elaborated hierarchy.
  if (WAIT_CYCLES > 15) begin : g_wait_cycles_out_of_range
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (resp_addr == AWIDTH'(i)) begin
        rd_sel = reg_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    prdata_d   = prdata_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    resp_go    = 1'b0;
    resp_err   = 1'b0;
    resp_addr  = addr_q;
    resp_write = write_q;
`ifdef APB_REGFILE_WAIT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d     = PADDR;
          write_d    = PWRITE;
          wdata_d    = PWDATA;
          // With no wait states the response is built from the bus directly.
          resp_addr  = PADDR;
          resp_write = PWRITE;
`ifdef APB_REGFILE_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            resp_go = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
`else
          resp_go = 1'b1;
`endif
        end
      end
      ST_WAIT: begin
`ifdef APB_REGFILE_WAIT_EN
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          resp_go = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESP: begin
        state_d   = ST_IDLE;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (resp_go) begin
      resp_err  = addr_err(32'(resp_addr), NREGS);
      state_d   = ST_RESP;
      pready_d  = 1'b1;
      pslverr_d = resp_err;
      prdata_d  = (!resp_write && !resp_err) ? rd_sel : '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

`ifdef APB_REGFILE_WAIT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // A dropped PSEL in RESP is an abort, so only a still-selected RESP commits.
  assign complete_wr = (state_q == ST_RESP) && PSEL && write_q && !addr_err(32'(addr_q), NREGS);

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    assign we[g] = complete_wr && (addr_q == AWIDTH'(g));

    apb_reg_cell #(
      .DWIDTH    (DWIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .we       (we[g]),
      .wdata    (wdata_q),
      .q        (reg_q[g]),
      .wr_pulse (wr_pulse[g])
    );

    assign regs_out[g*DWIDTH +: DWIDTH] = reg_q[g];
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile.sv
// tb/tb_apb_regfile.sv - randomized self-checking bench for apb_regfile against an array model
module tb_apb_regfile;

  localparam int         DW   = 8;
  localparam int         NR   = 4;
  localparam int         AW   = 4;
  localparam int         WC   = 3;
  localparam logic [7:0] RV   = 8'hA5;
`ifdef APB_REGFILE_WAIT_EN
  localparam int         EXP_LAT = WC + 1;
`else
  localparam int         EXP_LAT = 1;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0] wr_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] model [NR];

  apb_regfile #(
    .DWIDTH      (DW),
    .NREGS       (NR),
    .AWIDTH      (AW),
    .WAIT_CYCLES (WC),
    .RESET_VAL   (RV)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .regs_out (regs_out),
    .wr_pulse (wr_pulse)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [NR*DW-1:0] model_packed();
    logic [NR*DW-1:0] p;
    for (int i = 0; i < NR; i++) p[i*DW +: DW] = model[i];
    return p;
  endfunction

  // Starts just after a rising edge; returns just after the completion edge.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          output logic [DW-1:0] rdata, output logic err, output int lat);
    bit done;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PADDR   = AW'($urandom_range(0, 15));
    PWDATA  = DW'($urandom_range(0, 255));
    PWRITE  = 1'($urandom_range(0, 1));
    done = 0; lat = 0; rdata = '0; err = 1'b0;
    for (int n = 1; n <= 32 && !done; n++) begin
      @(negedge PCLK);
      if (PREADY) begin
        done = 1; lat = n; rdata = PRDATA; err = PSLVERR;
      end
      @(posedge PCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    if (!done) check("pready_timeout", 0, 1);
  endtask

  task automatic do_op(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       output logic [DW-1:0] rdata);
    logic err;
    int lat;
    logic exp_err;
    logic [DW-1:0] exp_rd;
    logic [NR-1:0] exp_pulse;
    exp_err   = (int'(addr) >= NR);
    exp_rd    = (!wr && !exp_err) ? model[addr[1:0]] : 8'h00;
    exp_pulse = (wr && !exp_err) ? NR'(1 << addr) : '0;
    apb_xfer(wr, addr, data, rdata, err, lat);
    if (wr && !exp_err) model[addr[1:0]] = data;
    check("latency", 64'(lat), 64'(EXP_LAT));
    check("pslverr", 64'(err), 64'(exp_err));
    check("prdata", 64'(rdata), 64'(exp_rd));
    check("regs_out", 64'(regs_out), 64'(model_packed()));
    check("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
    check("pready_low", 64'(PREADY), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] rd;
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    for (int i = 0; i < NR; i++) model[i] = RV;
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_pready", 64'(PREADY), 0);
    check("rst_pslverr", 64'(PSLVERR), 0);
    check("rst_prdata", 64'(PRDATA), 0);
    check("rst_wr_pulse", 64'(wr_pulse), 0);
    check("rst_regs", 64'(regs_out), 64'(model_packed()));
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < NR; i++) begin
      do_op(1'b0, AW'(i), 8'h00, rd);
      check("rst_read", 64'(rd), 64'(RV));
    end

    do_op(1'b1, 4'd2, 8'h3C, rd);
    check("w2_regs_slice", 64'(regs_out[23:16]), 64'h3C);
    check("w2_pulse", 64'(wr_pulse), 64'b0100);
    @(posedge PCLK); #1;
    check("w2_pulse_gone", 64'(wr_pulse), 0);
    do_op(1'b0, 4'd2, 8'h00, rd);
    check("w2_readback", 64'(rd), 64'h3C);

    do_op(1'b1, 4'd5, 8'hFF, rd);
    check("err_pulse", 64'(wr_pulse), 0);

    do_op(1'b1, 4'd0, 8'h11, rd);
    do_op(1'b0, 4'd0, 8'h00, rd);
    check("b2b_read", 64'(rd), 64'h11);

    // PSEL dropped in the access phase: no write must land.
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 4'd3; PWDATA = 8'h55;
    @(posedge PCLK); #1;
    PSEL = 0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("abort_regs", 64'(regs_out), 64'(model_packed()));
    check("abort_pulse", 64'(wr_pulse), 0);
    check("abort_pready", 64'(PREADY), 0);

    for (int k = 0; k < 40; k++) begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 7));
      d = DW'($urandom_range(0, 255));
      do_op(w, a, d, rd);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge PCLK); #1;
        check("idle_pulse", 64'(wr_pulse), 0);
      end
    end

    // Reset in the middle of a write to register 1.
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 4'd1; PWDATA = 8'h77;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #2 PRESETn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = RV;
    check("midrst_pready", 64'(PREADY), 0);
    check("midrst_pslverr", 64'(PSLVERR), 0);
    check("midrst_prdata", 64'(PRDATA), 0);
    check("midrst_pulse", 64'(wr_pulse), 0);
    check("midrst_reg1", 64'(regs_out[15:8]), 64'(RV));
    PSEL = 0; PENABLE = 0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("postrst_regs", 64'(regs_out), 64'(model_packed()));
    check("postrst_pulse", 64'(wr_pulse), 0);
    do_op(1'b0, 4'd1, 8'h00, rd);
    check("postrst_read1", 64'(rd), 64'(RV));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
